fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that owns the program counter feeding the combinational instruction memory and the IF/ID pipeline register it loads. It advances the PC by 4 each cycle, holds it on hazard-unit stalls, and applies branch/jump redirects from ID, buffering one redirect that arrives during a stall. It also detects out-of-range or misaligned fetch addresses and halts fetch with a sticky fault.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- IM_WORDS, 1024, instruction memory depth in 32-bit words; legal range is RESET_PC to RESET_PC + 4*IM_WORDS - 4.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  hazard-unit stall; holds the PC and IF/ID.
- redirect_valid  in  1  branch/jump taken in ID this cycle.
- redirect_pc  in  32  target of the redirect.
- im_instr  in  32  instruction read combinationally from IM at pc.
- pc  out  32  fetch address driven to IM.
- if_id_instr  out  32  registered instruction to ID.
- if_id_pc  out  32  registered PC of if_id_instr.
- if_id_valid  out  1  if_id_instr is a real fetched instruction, not a bubble.
- fetch_fault  out  1  sticky fault: illegal fetch address.
- fetch_count  out  32  instructions fetched into IF/ID since reset.

## Operation
- States: BOOT, RUN, HALT. Reset enters BOOT.
- BOOT: lasts exactly one cycle. Loads nothing into IF/ID and moves to RUN. pc is RESET_PC.
- RUN, stall=0, no redirect or pending redirect:
  - IF/ID loads {im_instr, pc} with valid=1.
  - fetch_count increments.
  - pc <= pc + 4.
- RUN, stall=1:
  - pc, IF/ID and fetch_count hold.
  - If redirect_valid=1, redirect_pc goes into a one-entry pending register. A later redirect during the same stall overwrites it.
- RUN, stall=0, redirect applies (redirect_valid=1, or the pending register is full):
  - IF/ID loads the current fetch normally. This is the delay-slot instruction and is never squashed.
  - pc <= redirect_pc. A live redirect_valid takes priority over the pending value.
  - The pending register clears.
- Fault check:
  - A fault is raised when pc is evaluated in RUN with stall=0 and either pc[1:0] != 0 or pc is outside the legal range.
  - On fault, IF/ID loads instr=0 (nop) with valid=0, fetch_count does not increment, fetch_fault sets, and the state goes to HALT.
- HALT:
  - pc frozen.
  - if_id_valid=0 and if_id_instr=0 every cycle.
  - stall and redirects ignored.
  - Exit only by reset.
- Arithmetic: pc + 4 wraps modulo 2^32; the wrapped value then faults. fetch_count wraps modulo 2^32.

## Timing
- Reset values:
  - pc = RESET_PC
  - if_id_instr = 0
  - if_id_pc = RESET_PC
  - if_id_valid = 0
  - fetch_fault = 0
  - fetch_count = 0
  - pending register empty
  - state BOOT
- Reset asserted mid-operation clears everything immediately (asynchronous), including a pending redirect and a HALT.
- IM is combinational. The instruction at pc appears in IF/ID one clock edge after pc is presented, provided stall=0.
- The first valid IF/ID instruction comes 2 edges after reset release: edge 1 leaves BOOT, edge 2 loads the instruction at RESET_PC.
- Redirect latency: redirect_valid sampled at edge N (with stall=0) puts redirect_pc on pc after edge N, and the target instruction enters IF/ID at edge N+1.
- A pending redirect applies at the first edge where stall=0.
- A stall held for k cycles adds exactly k cycles to every subsequent latency.

## Structure
- Shared package (cpu_defs), used by hazard unit and testbench:
  - RESET_PC default
  - NOP encoding 32'h0
  - fetch state enum {BOOT, RUN, HALT}
- One natural sub-module: fetch_pc_reg, holding the PC register, the pending-redirect register and the next-PC mux.
- The top holds the FSM, IF/ID register, fault check and counter. IM is instantiated outside, at the CPU top.

## Test plan
- Straight-line fetch: release reset, no stall, 5 cycles.
  - IF/ID sequence is {3000, 3004, 3008} with valid=1 from the 2nd edge on.
  - fetch_count = 3 after edge 4.
- Stall: assert stall for 3 cycles while pc=0x3008.
  - pc stays 0x3008 and if_id_pc stays 0x3004.
  - On release, IF/ID receives 0x3008 with no gap.
- Redirect: redirect_valid=1, redirect_pc=0x3040 while pc=0x300C.
  - IF/ID receives 0x300C (delay slot), then 0x3040.
- Redirect during stall: with stall=1, redirect to 0x3080, then to 0x3100 the next cycle; release stall.
  - Current fetch is delivered, then pc=0x3100; 0x3080 is never fetched.
- Fault: redirect to 0x3002, and separately to 0x3000 + 4*IM_WORDS.
  - fetch_fault=1, state HALT, if_id_valid=0, pc frozen; all three hold through further redirects.
- Async reset mid-HALT and mid-stall with a pending redirect.
  - All outputs return to their reset values without a clock edge; the pending redirect is discarded.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: reset vector, NOP encoding, fetch FSM states and
// the fetch-address legality helper used by fetch logic and its bench.
package cpu_defs;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_t;

  // A fetch address is legal when word aligned and inside [first, last].
  function automatic logic fetch_addr_ok(input logic [31:0] addr,
                                         input logic [31:0] first,
                                         input logic [31:0] last);
    return (addr[1:0] == 2'b00) && (addr >= first) && (addr <= last);
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_reg.sv
// Program counter, one-entry pending-redirect buffer and next-PC selection.
module fetch_pc_reg
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        capture,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  logic        pend_valid;
  logic [31:0] pend_pc;
  logic [31:0] pc_next;

  // Next fetch address: live redirect beats buffered one, otherwise sequential.
  always_comb begin
    pc_next = pc + 32'd4;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (pend_valid) begin
      pc_next = pend_pc;
    end
  end

  // PC and pending-redirect registers; the buffer drains whenever the PC moves.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc         <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= 32'h0;
    end else if (advance) begin
      pc         <= pc_next;
      pend_valid <= 1'b0;
    end else if (capture) begin
      pend_valid <= 1'b1;
      pend_pc    <= redirect_pc;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: boot/run/halt FSM, IF/ID register, fault
// detection and fetched-instruction counter around the PC sub-block.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   FS_BOOT | one cycle after reset, nothing loaded into IF/ID
//   FS_RUN  | fetching; stall holds, redirects applied or buffered
//   FS_HALT | illegal fetch address seen; frozen until reset
module fetch_sequencer
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter int          IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] im_instr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PC_LAST = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;

  fetch_state_t state, state_next;
  logic         addr_bad;
  logic         pc_advance;
  logic         pend_capture;
  logic         load_fetch;
  logic         load_fault;

  fetch_pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .reset         (reset),
    .advance       (pc_advance),
    .capture       (pend_capture),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .pc            (pc)
  );

  // A wrapped pc + 4 lands below RESET_PC, so it is caught by the range test.
  assign addr_bad = !fetch_addr_ok(pc, RESET_PC, PC_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FS_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_next   = state;
    pc_advance   = 1'b0;
    pend_capture = 1'b0;
    load_fetch   = 1'b0;
    load_fault   = 1'b0;
    case (state)
      FS_BOOT: begin
        state_next = FS_RUN;
      end
      FS_RUN: begin
        if (stall) begin
          pend_capture = redirect_valid;
        end else if (addr_bad) begin
          load_fault = 1'b1;
          state_next = FS_HALT;
        end else begin
          load_fetch = 1'b1;
          pc_advance = 1'b1;
        end
      end
      FS_HALT: begin
        state_next = FS_HALT;
      end
      default: begin
        state_next = FS_HALT;
      end
    endcase
  end

  // IF/ID register; a fault or halt inserts bubbles and keeps the last pc.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_id_instr <= NOP;
      if_id_pc    <= RESET_PC;
      if_id_valid <= 1'b0;
    end else if (load_fetch) begin
      if_id_instr <= im_instr;
      if_id_pc    <= pc;
      if_id_valid <= 1'b1;
    end else if (load_fault || (state == FS_HALT)) begin
      if_id_instr <= NOP;
      if_id_valid <= 1'b0;
    end
  end

  // Sticky fault flag and fetched-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_fault <= 1'b0;
      fetch_count <= 32'h0;
    end else begin
      if (load_fault) begin
        fetch_fault <= 1'b1;
      end
      if (load_fetch) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: vector table plus reset corner cases.
module tb_fetch_sequencer;
  import cpu_defs::*;

  localparam logic [31:0] IM_KEY = 32'hDEAD_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] im_instr;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(
    .RESET_PC(32'h0000_3000),
    .IM_WORDS(1024)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .im_instr      (im_instr),
    .pc            (pc),
    .if_id_instr   (if_id_instr),
    .if_id_pc      (if_id_pc),
    .if_id_valid   (if_id_valid),
    .fetch_fault   (fetch_fault),
    .fetch_count   (fetch_count)
  );

  // Instruction memory model: content derived from the address.
  assign im_instr = pc ^ IM_KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic [31:0] e_ifpc;
    logic        chk_ifpc;
    logic        e_v;
    logic [31:0] e_cnt;
    logic        e_flt;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic st, input logic rv, input logic [31:0] rpc,
                              input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                              input logic chk_ifpc, input logic e_v,
                              input logic [31:0] e_cnt, input logic e_flt);
    vec_t v;
    v.st = st; v.rv = rv; v.rpc = rpc; v.e_pc = e_pc; v.e_ifpc = e_ifpc;
    v.chk_ifpc = chk_ifpc; v.e_v = e_v; v.e_cnt = e_cnt; v.e_flt = e_flt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [31:0] e_pc, input logic [31:0] e_ifpc,
                         input logic chk_ifpc, input logic e_v, input logic [31:0] e_cnt,
                         input logic e_flt);
    chk({nm, "_pc"}, pc, e_pc);
    if (chk_ifpc) chk({nm, "_ifpc"}, if_id_pc, e_ifpc);
    chk({nm, "_valid"}, {31'h0, if_id_valid}, {31'h0, e_v});
    chk({nm, "_instr"}, if_id_instr, e_v ? (e_ifpc ^ IM_KEY) : NOP);
    chk({nm, "_count"}, fetch_count, e_cnt);
    chk({nm, "_fault"}, {31'h0, fetch_fault}, {31'h0, e_flt});
  endtask

  task automatic step(input logic st, input logic rv, input logic [31:0] rpc);
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  // Async reset applied between edges; checked before any clock edge.
  task automatic async_reset_check(input string nm);
    #2;
    reset = 1'b0;
    #1;
    chk_all(nm, 32'h3000, 32'h3000, 1'b1, 1'b0, 32'd0, 1'b0);
    stall = 1'b0;
    redirect_valid = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    //                st    rv    rpc           pc            ifpc        ck   v     cnt   flt
    vecs[0]  = mk(1'b0, 1'b0, 32'h0,     32'h3000, 32'h3000, 1'b1, 1'b0, 32'd0, 1'b0); // boot
    vecs[1]  = mk(1'b0, 1'b0, 32'h0,     32'h3004, 32'h3000, 1'b1, 1'b1, 32'd1, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,     32'h3008, 32'h3004, 1'b1, 1'b1, 32'd2, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0,     32'h3008, 32'h3004, 1'b1, 1'b1, 32'd2, 1'b0); // stall x3
    vecs[4]  = mk(1'b1, 1'b0, 32'h0,     32'h3008, 32'h3004, 1'b1, 1'b1, 32'd2, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 32'h0,     32'h3008, 32'h3004, 1'b1, 1'b1, 32'd2, 1'b0);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0,     32'h300C, 32'h3008, 1'b1, 1'b1, 32'd3, 1'b0);
    vecs[7]  = mk(1'b0, 1'b1, 32'h3040,  32'h3040, 32'h300C, 1'b1, 1'b1, 32'd4, 1'b0); // delay slot
    vecs[8]  = mk(1'b0, 1'b0, 32'h0,     32'h3044, 32'h3040, 1'b1, 1'b1, 32'd5, 1'b0);
    vecs[9]  = mk(1'b1, 1'b1, 32'h3080,  32'h3044, 32'h3040, 1'b1, 1'b1, 32'd5, 1'b0); // buffered
    vecs[10] = mk(1'b1, 1'b1, 32'h3100,  32'h3044, 32'h3040, 1'b1, 1'b1, 32'd5, 1'b0); // overwrite
    vecs[11] = mk(1'b1, 1'b0, 32'h0,     32'h3044, 32'h3040, 1'b1, 1'b1, 32'd5, 1'b0);
    vecs[12] = mk(1'b0, 1'b0, 32'h0,     32'h3100, 32'h3044, 1'b1, 1'b1, 32'd6, 1'b0);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,     32'h3104, 32'h3100, 1'b1, 1'b1, 32'd7, 1'b0);
    vecs[14] = mk(1'b0, 1'b1, 32'h3002,  32'h3002, 32'h3104, 1'b1, 1'b1, 32'd8, 1'b0); // misaligned
    vecs[15] = mk(1'b0, 1'b0, 32'h0,     32'h3002, 32'h0,    1'b0, 1'b0, 32'd8, 1'b1); // fault
    vecs[16] = mk(1'b0, 1'b1, 32'h3200,  32'h3002, 32'h0,    1'b0, 1'b0, 32'd8, 1'b1);
    vecs[17] = mk(1'b1, 1'b1, 32'h3300,  32'h3002, 32'h0,    1'b0, 1'b0, 32'd8, 1'b1);

    #11;
    chk_all("reset", 32'h3000, 32'h3000, 1'b1, 1'b0, 32'd0, 1'b0);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(vecs[i].st, vecs[i].rv, vecs[i].rpc);
      chk_all($sformatf("v%0d", i), vecs[i].e_pc, vecs[i].e_ifpc, vecs[i].chk_ifpc,
              vecs[i].e_v, vecs[i].e_cnt, vecs[i].e_flt);
    end

    // Reset out of HALT, then the upper range boundary.
    async_reset_check("rst_halt");
    step(1'b0, 1'b0, 32'h0);
    chk_all("hi_boot", 32'h3000, 32'h3000, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b1, 32'h3FFC);
    chk_all("hi_redir", 32'h3FFC, 32'h3000, 1'b1, 1'b1, 32'd1, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk_all("hi_last", 32'h4000, 32'h3FFC, 1'b1, 1'b1, 32'd2, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk_all("hi_fault", 32'h4000, 32'h0, 1'b0, 1'b0, 32'd2, 1'b1);
    step(1'b0, 1'b1, 32'h3000);
    chk_all("hi_hold", 32'h4000, 32'h0, 1'b0, 1'b0, 32'd2, 1'b1);

    // Reset during a stall with a buffered redirect; the redirect is dropped.
    async_reset_check("rst_pre");
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    chk_all("ps_fetch", 32'h3004, 32'h3000, 1'b1, 1'b1, 32'd1, 1'b0);
    step(1'b1, 1'b1, 32'h3080);
    chk_all("ps_stall", 32'h3004, 32'h3000, 1'b1, 1'b1, 32'd1, 1'b0);
    async_reset_check("rst_stall");
    step(1'b0, 1'b0, 32'h0);
    chk_all("ps_boot", 32'h3000, 32'h3000, 1'b1, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk_all("ps_nopend", 32'h3004, 32'h3000, 1'b1, 1'b1, 32'd1, 1'b0);

    // Below the lower bound.
    step(1'b0, 1'b1, 32'h2FFC);
    chk_all("lo_redir", 32'h2FFC, 32'h3004, 1'b1, 1'b1, 32'd2, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    chk_all("lo_fault", 32'h2FFC, 32'h0, 1'b0, 1'b0, 32'd2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
